// File: rtl/ram_1kx8_pkg.sv
// ram_pkg: shared defaults and word/address typedefs for the 1k x 8 scratch RAM.
//   DATA_W : data word width in bits
//   ADDR_W : address width in bits
//   DEPTH  : number of words (must be <= 2**ADDR_W)
package ram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/ram_1kx8_if.sv
// ram_1kx8_if: access bus for the single-port RAM.
//   data_i : write data          (master -> slave)
//   addr_i : shared r/w address  (master -> slave)
//   WEn_i  : write enable, high  (master -> slave)
//   data_o : registered read data (slave -> master)
// Handshake: there is no valid/ready pair. Every rising clock edge is a
// transaction: the slave samples addr_i/data_i/WEn_i at the edge and
// presents the read result on data_o after that same edge.
interface ram_1kx8_if #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W
);

  logic [DATA_W-1:0] data_i;
  logic [ADDR_W-1:0] addr_i;
  logic              WEn_i;
  logic [DATA_W-1:0] data_o;

  modport master (
    output data_i,
    output addr_i,
    output WEn_i,
    input  data_o
  );

  modport slave (
    input  data_i,
    input  addr_i,
    input  WEn_i,
    output data_o
  );

endinterface : ram_1kx8_if

// File: rtl/ram_1kx8_array.sv
// ram_1kx8_array: storage array with synchronous write and combinational
// read. No reset on the array so that it maps onto block RAM; the read
// register lives in the parent and is absorbed into the RAM output stage.
//   clk     : write clock
//   wr_en   : write strobe (already range-checked and reset-gated)
//   addr    : word address
//   wr_data : write data
//   rd_data : contents of mem[addr]
module ram_1kx8_array #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DEPTH  = ram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule : ram_1kx8_array

// File: rtl/ram_1kx8.sv
// ram_1kx8: single-port synchronous scratch RAM, one-cycle read latency,
// write-first on a simultaneous read/write of the same address.
//   Clk   : clock, all updates on the rising edge
//   Rst_n : asynchronous active-low reset; clears data_o only, the
//           memory contents survive reset
//   bus   : ram_1kx8_if slave (data_i, addr_i, WEn_i in; data_o out)
module ram_1kx8 #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DEPTH  = ram_pkg::DEPTH
) (
  input  logic       Clk,
  input  logic       Rst_n,
  ram_1kx8_if.slave  bus
);

  import ram_pkg::*;

  // One extra bit so that DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              in_range;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] data_q;

  assign in_range = ({1'b0, bus.addr_i} < DEPTH_L);

  // Rst_n gates the strobe because the array itself has no reset.
  assign wr_en = bus.WEn_i & in_range & Rst_n;

  ram_1kx8_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (Clk),
    .wr_en   (wr_en),
    .addr    (bus.addr_i),
    .wr_data (bus.data_i),
    .rd_data (rd_data)
  );

  // Output register: out-of-range reads give 0, a write bypasses the
  // array so the new word appears at the same edge (write-first).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q <= '0;
    end else if (!in_range) begin
      data_q <= '0;
    end else if (bus.WEn_i) begin
      data_q <= bus.data_i;
    end else begin
      data_q <= rd_data;
    end
  end

  assign bus.data_o = data_q;

endmodule : ram_1kx8

// File: tb/tb_ram_1kx8.sv
module tb_ram_1kx8;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;

  logic Clk;
  logic Rst_n;

  int n_tests;
  int n_fail;

  ram_1kx8_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
  ram_1kx8_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_r ();

  // Full-depth instance and a DEPTH=1000 instance for the range checks.
  ram_1kx8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(1024)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_a)
  );

  ram_1kx8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(1000)) dut_r (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_r)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  // driver: apply inputs to both instances, then wait one edge and settle
  task automatic step(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic we);
    bus_a.addr_i = a;
    bus_a.data_i = d;
    bus_a.WEn_i  = we;
    bus_r.addr_i = a;
    bus_r.data_i = d;
    bus_r.WEn_i  = we;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Rst_n   = 1'b0;
    bus_a.addr_i = '0; bus_a.data_i = '0; bus_a.WEn_i = 1'b0;
    bus_r.addr_i = '0; bus_r.data_i = '0; bus_r.WEn_i = 1'b0;

    // power-on reset
    repeat (2) @(posedge Clk);
    #1;
    check("reset_a", bus_a.data_o, 8'h00);
    check("reset_r", bus_r.data_o, 8'h00);
    Rst_n = 1'b1;

    // reset mid-run: data_o clears immediately, memory survives
    step(10'd5, 8'hA5, 1'b1);
    check("wr5_first", bus_a.data_o, 8'hA5);
    step(10'd5, 8'h00, 1'b0);
    check("rd5", bus_a.data_o, 8'hA5);
    Rst_n = 1'b0;
    #1;
    check("async_clear", bus_a.data_o, 8'h00);
    // writes attempted during reset must be blocked
    step(10'd5, 8'h3C, 1'b1);
    check("held_in_reset", bus_a.data_o, 8'h00);
    step(10'd5, 8'h3C, 1'b1);
    bus_a.WEn_i = 1'b0;
    bus_r.WEn_i = 1'b0;
    #2;
    Rst_n = 1'b1;
    step(10'd5, 8'h00, 1'b0);
    check("rd5_after_reset", bus_a.data_o, 8'hA5);

    // fill: write-first shows each new word at the write edge
    for (int i = 0; i < 1024; i++) begin
      logic [DATA_W-1:0] e_r;
      step(ADDR_W'(i), DATA_W'(i), 1'b1);
      e_r = (i < 1000) ? DATA_W'(i) : 8'h00;
      check("fill_a", bus_a.data_o, DATA_W'(i));
      check("fill_r", bus_r.data_o, e_r);
    end

    // read back
    for (int i = 0; i < 1024; i++) begin
      step(ADDR_W'(i), 8'h00, 1'b0);
      check("read_a", bus_a.data_o, DATA_W'(i));
    end

    // table: WEn low, write-first, back-to-back, neighbour, top address
    vecs[0] = '{addr: 10'd10,   data: 8'h3C, we: 1'b0, exp: 8'h0A};
    vecs[1] = '{addr: 10'd10,   data: 8'h00, we: 1'b0, exp: 8'h0A};
    vecs[2] = '{addr: 10'd20,   data: 8'h77, we: 1'b1, exp: 8'h77};
    vecs[3] = '{addr: 10'd20,   data: 8'h00, we: 1'b0, exp: 8'h77};
    vecs[4] = '{addr: 10'd0,    data: 8'h11, we: 1'b1, exp: 8'h11};
    vecs[5] = '{addr: 10'd1,    data: 8'h22, we: 1'b1, exp: 8'h22};
    vecs[6] = '{addr: 10'd0,    data: 8'h00, we: 1'b0, exp: 8'h11};
    vecs[7] = '{addr: 10'd1,    data: 8'h00, we: 1'b0, exp: 8'h22};
    vecs[8] = '{addr: 10'd2,    data: 8'h00, we: 1'b0, exp: 8'h02};
    vecs[9] = '{addr: 10'd1023, data: 8'h00, we: 1'b0, exp: 8'hFF};
    for (int v = 0; v < 10; v++) begin
      step(vecs[v].addr, vecs[v].data, vecs[v].we);
      check($sformatf("vec%0d", v), bus_a.data_o, vecs[v].exp);
    end

    // range: DEPTH=1000 ignores addr 1000 and returns 0
    step(10'd999, 8'h00, 1'b0);
    check("range_rd999_pre", bus_r.data_o, 8'hE7);
    step(10'd1000, 8'h55, 1'b1);
    check("range_wr1000", bus_r.data_o, 8'h00);
    check("full_wr1000", bus_a.data_o, 8'h55);
    step(10'd999, 8'h00, 1'b0);
    check("range_rd999", bus_r.data_o, 8'hE7);
    step(10'd1000, 8'h00, 1'b0);
    check("range_rd1000", bus_r.data_o, 8'h00);
    check("full_rd1000", bus_a.data_o, 8'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_1kx8
